// File: rtl/io_pkg.sv
// Shared types and widths for the bidirectional pad port family.
package io_pkg;

   typedef enum logic [1:0] {
      IN    = 2'd0,
      TURN  = 2'd1,
      DRIVE = 2'd2
   } io_state_e;

   // Counter widths cover the whole legal parameter range, so one package
   // serves every instance regardless of its TURN_CYCLES / SYNC_STAGES.
   localparam int TURN_CYCLES_MAX = 15;
   localparam int SYNC_STAGES_MAX = 4;
   localparam int TURN_W          = $clog2(TURN_CYCLES_MAX + 1);
   localparam int FLUSH_W         = $clog2(SYNC_STAGES_MAX + 1);

endpackage

// File: rtl/io_sync_chain.sv
// Per-bit multi-flop input synchroniser with enable; reusable by other pad blocks.
module io_sync_chain #(
   parameter int BITS        = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [BITS-1:0] d,
   output logic [BITS-1:0] q
);

   logic [BITS-1:0] stage [SYNC_STAGES];

   // Shift pad samples down the chain on every enabled cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      end else if (en) begin
         stage[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_io_port.sv
// Registered bidirectional pad port: input sync + edge detect, output latch,
// and a fixed tristate dead time on every direction change.
//
//   state | meaning
//   IN    | pads released, synchronised pad value feeds data_out
//   TURN  | dead time, nobody drives; counts turn_cnt down to 0, then -> target
//   DRIVE | pads driven from out_q
module bidir_io_port #(
   parameter int BITS        = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TURN_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            direction,
   input  logic            wr,
   input  logic [BITS-1:0] data_in,
   output logic [BITS-1:0] data_out,
   output logic            data_valid,
   output logic [BITS-1:0] edge_rise,
   output logic [BITS-1:0] edge_fall,
   output logic            busy,
   output logic            drive_en,
   inout  wire  [BITS-1:0] io_port
);

   import io_pkg::*;

   io_state_e          state;
   io_state_e          target;
   logic [TURN_W-1:0]  turn_cnt;
   logic [FLUSH_W-1:0] flush_cnt;
   logic [BITS-1:0]    out_q;
   logic [BITS-1:0]    sync_q;

   io_sync_chain #(
      .BITS        (BITS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (io_port),
      .q     (sync_q)
   );

   assign io_port = drive_en ? out_q : {BITS{1'bz}};

   // Direction FSM, turnaround/flush counters, output latch and edge detect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IN;
         target     <= IN;
         turn_cnt   <= '0;
         flush_cnt  <= FLUSH_W'(SYNC_STAGES);
         out_q      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         edge_rise  <= '0;
         edge_fall  <= '0;
         busy       <= 1'b0;
         drive_en   <= 1'b0;
      end else if (!en) begin
         edge_rise <= '0;
         edge_fall <= '0;
      end else begin
         if (wr) out_q <= data_in;
         edge_rise <= '0;
         edge_fall <= '0;
         case (state)
            IN: begin
               data_out <= sync_q;
               // Edges only once data_out tracks a flushed chain, and not on
               // the cycle we leave IN.
               if (data_valid && !direction) begin
                  edge_rise <= sync_q & ~data_out;
                  edge_fall <= ~sync_q & data_out;
               end
               if (flush_cnt != '0) flush_cnt <= flush_cnt - FLUSH_W'(1);
               // Lags the flush count by one so data_out is already caught up.
               data_valid <= (flush_cnt == '0);
               if (direction) begin
                  state      <= TURN;
                  target     <= DRIVE;
                  turn_cnt   <= TURN_W'(TURN_CYCLES - 1);
                  busy       <= 1'b1;
                  data_valid <= 1'b0;
               end
            end
            TURN: begin
               if (turn_cnt == '0) begin
                  state <= target;
                  busy  <= 1'b0;
                  if (target == DRIVE) begin
                     drive_en <= 1'b1;
                  end else begin
                     flush_cnt  <= FLUSH_W'(SYNC_STAGES);
                     data_valid <= 1'b0;
                  end
               end else begin
                  turn_cnt <= turn_cnt - TURN_W'(1);
               end
            end
            DRIVE: begin
               drive_en <= 1'b1;
               if (!direction) begin
                  state    <= TURN;
                  target   <= IN;
                  turn_cnt <= TURN_W'(TURN_CYCLES - 1);
                  busy     <= 1'b1;
                  drive_en <= 1'b0;
               end
            end
            default: state <= IN;
         endcase
      end
   end

endmodule
